jtag_axi_burst_dispatch: RTL

- AXI4 master engine for the JTAG-to-AXI bridge: single-beat access generalised to INCR bursts of up to MAX_BURST_LEN beats.
- Adds a buffered read-return FIFO, per-burst worst-case response accumulation and legality checks (length, size, 4 KB crossing).
- Sits on the AXI clock side behind the CDC FIFO, which delivers request descriptors and write beats.
- Reports one status record per request.

---
 rtl/jtag_axi_burst_dispatch.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_axi_burst_dispatch.sv
// AXI4 INCR-burst master for the JTAG-to-AXI bridge: legality checks, timeout abort,
// first-word fall-through read-return FIFO and one status record per request.
package amba_axi_pkg;
    parameter int unsigned AXI_ADDR_WIDTH = 32;
    parameter int unsigned AXI_DATA_WIDTH = 32;
    parameter int unsigned AXI_ID_WIDTH   = 4;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     awid;
        logic [AXI_ADDR_WIDTH-1:0]   awaddr;
        logic [7:0]                  awlen;
        logic [2:0]                  awsize;
        logic [1:0]                  awburst;
        logic                        awlock;
        logic [3:0]                  awcache;
        logic [2:0]                  awprot;
        logic [3:0]                  awqos;
        logic                        awvalid;
        logic [AXI_DATA_WIDTH-1:0]   wdata;
        logic [AXI_DATA_WIDTH/8-1:0] wstrb;
        logic                        wlast;
        logic                        wvalid;
        logic                        bready;
        logic [AXI_ID_WIDTH-1:0]     arid;
        logic [AXI_ADDR_WIDTH-1:0]   araddr;
        logic [7:0]                  arlen;
        logic [2:0]                  arsize;
        logic [1:0]                  arburst;
        logic                        arlock;
        logic [3:0]                  arcache;
        logic [2:0]                  arprot;
        logic [3:0]                  arqos;
        logic                        arvalid;
        logic                        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                        awready;
        logic                        wready;
        logic [AXI_ID_WIDTH-1:0]     bid;
        logic [1:0]                  bresp;
        logic                        bvalid;
        logic                        arready;
        logic [AXI_ID_WIDTH-1:0]     rid;
        logic [AXI_DATA_WIDTH-1:0]   rdata;
        logic [1:0]                  rresp;
        logic                        rlast;
        logic                        rvalid;
    } s_axi_miso_t;
endpackage

module jtag_axi_burst_dispatch
    import amba_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned AXI_MASTER_ID  = 1,
    parameter int unsigned AXI_TIMEOUT_CC = 4096,
    parameter int unsigned MAX_BURST_LEN  = 16,
    parameter int unsigned RD_FIFO_DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    aresn,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [7:0]              req_len_i,
    input  logic [2:0]              req_size_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic                    sts_valid_o,
    output logic [1:0]              sts_resp_o,
    output logic                    sts_timeout_o,
    output logic                    sts_illegal_o,
    output logic [8:0]              sts_beats_o,
    output logic                    busy_o,
    output s_axi_mosi_t             jtag_axi_mosi_o,
    input  s_axi_miso_t             jtag_axi_miso_i
);
    if (ADDR_WIDTH != AXI_ADDR_WIDTH) begin : g_addr_width_chk
        $error("ADDR_WIDTH must equal amba_axi_pkg address width");
    end
    if (DATA_WIDTH != AXI_DATA_WIDTH) begin : g_data_width_chk
        $error("DATA_WIDTH must equal amba_axi_pkg data width");
    end
    if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > 256) begin : g_burst_chk
        $error("MAX_BURST_LEN must be within 1..256");
    end
    if (RD_FIFO_DEPTH < 2 || (RD_FIFO_DEPTH & (RD_FIFO_DEPTH - 1)) != 0) begin : g_fifo_chk
        $error("RD_FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int unsigned PtrW = $clog2(RD_FIFO_DEPTH);
    localparam int unsigned TmoW = $clog2(AXI_TIMEOUT_CC);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(AXI_TIMEOUT_CC - 1);

    typedef enum logic [2:0] {StIdle, StCheck, StAw, StW, StB, StAr, StR, StStatus} state_e;

    state_e                state_q;
    logic                  req_ready_q, aw_valid_q, ar_valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic [8:0]            beats_q;
    logic [1:0]            resp_q;
    logic [TmoW-1:0]       tmo_q;
    logic                  sts_valid_q, sts_timeout_q, sts_illegal_q;
    logic [1:0]            sts_resp_q;
    logic [8:0]            sts_beats_q;

    logic [DATA_WIDTH-1:0] fifo_mem [RD_FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]         count_q;

    logic        fifo_full, rd_push, rd_pop, r_ready, w_last;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, timed, illegal;
    logic [8:0]  len_plus1;
    logic [31:0] end_off;
    logic [1:0]  resp_max;
    s_axi_mosi_t axi_mosi;
    logic        unused_ids;

    assign len_plus1 = {1'b0, len_q} + 9'd1;
    // Burst must end no later than the 4 KB page boundary it started in.
    assign end_off   = {20'd0, addr_q[11:0]} + (32'(len_plus1) << size_q);
    assign illegal   = (32'(len_plus1) > MAX_BURST_LEN) ||
                       ((32'd1 << size_q) > DATA_WIDTH / 8) ||
                       (end_off > 32'd4096);

    assign fifo_full = (count_q == (PtrW + 1)'(RD_FIFO_DEPTH));
    assign r_ready   = (state_q == StR) && !fifo_full;
    assign w_last    = (state_q == StW) && (beats_q == {1'b0, len_q});

    assign aw_hs  = (state_q == StAw) && aw_valid_q && jtag_axi_miso_i.awready;
    assign w_hs   = (state_q == StW) && wr_valid_i && jtag_axi_miso_i.wready;
    assign b_hs   = (state_q == StB) && jtag_axi_miso_i.bvalid;
    assign ar_hs  = (state_q == StAr) && ar_valid_q && jtag_axi_miso_i.arready;
    assign r_hs   = r_ready && jtag_axi_miso_i.rvalid;
    assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign timed  = (state_q == StAw) || (state_q == StW) || (state_q == StB) ||
                    (state_q == StAr) || (state_q == StR);

    assign resp_max = (jtag_axi_miso_i.rresp > resp_q) ? jtag_axi_miso_i.rresp : resp_q;

    always_ff @(posedge clk or negedge aresn) begin
        if (!aresn) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b0;
            aw_valid_q    <= 1'b0;
            ar_valid_q    <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            size_q        <= '0;
            write_q       <= 1'b0;
            beats_q       <= '0;
            resp_q        <= '0;
            tmo_q         <= '0;
            sts_valid_q   <= 1'b0;
            sts_resp_q    <= '0;
            sts_timeout_q <= 1'b0;
            sts_illegal_q <= 1'b0;
            sts_beats_q   <= '0;
        end else begin
            sts_valid_q <= 1'b0;
            if (timed) tmo_q <= any_hs ? '0 : tmo_q + 1'b1;

            if (timed && !any_hs && tmo_q == TmoMax) begin
                aw_valid_q    <= 1'b0;
                ar_valid_q    <= 1'b0;
                state_q       <= StStatus;
                sts_valid_q   <= 1'b1;
                sts_resp_q    <= 2'b10;
                sts_timeout_q <= 1'b1;
                sts_illegal_q <= 1'b0;
                sts_beats_q   <= beats_q;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        req_ready_q <= 1'b1;
                        if (req_valid_i && req_ready_q) begin
                            req_ready_q <= 1'b0;
                            addr_q      <= req_addr_i;
                            len_q       <= req_len_i;
                            size_q      <= req_size_i;
                            write_q     <= req_write_i;
                            beats_q     <= '0;
                            resp_q      <= '0;
                            state_q     <= StCheck;
                        end
                    end
                    StCheck: begin
                        tmo_q <= '0;
                        if (illegal) begin
                            state_q       <= StStatus;
                            sts_valid_q   <= 1'b1;
                            sts_resp_q    <= 2'b10;
                            sts_timeout_q <= 1'b0;
                            sts_illegal_q <= 1'b1;
                            sts_beats_q   <= '0;
                        end else if (write_q) begin
                            aw_valid_q <= 1'b1;
                            state_q    <= StAw;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= StAr;
                        end
                    end
                    StAw: if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        state_q    <= StW;
                    end
                    StW: if (w_hs) begin
                        beats_q <= beats_q + 9'd1;
                        if (w_last) state_q <= StB;
                    end
                    StB: if (b_hs) begin
                        state_q       <= StStatus;
                        sts_valid_q   <= 1'b1;
                        sts_resp_q    <= jtag_axi_miso_i.bresp;
                        sts_timeout_q <= 1'b0;
                        sts_illegal_q <= 1'b0;
                        sts_beats_q   <= beats_q;
                    end
                    StAr: if (ar_hs) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= StR;
                    end
                    StR: if (r_hs) begin
                        beats_q <= beats_q + 9'd1;
                        resp_q  <= resp_max;
                        // RLAST alone ends the burst, even past the requested length.
                        if (jtag_axi_miso_i.rlast) begin
                            state_q       <= StStatus;
                            sts_valid_q   <= 1'b1;
                            sts_resp_q    <= resp_max;
                            sts_timeout_q <= 1'b0;
                            sts_illegal_q <= 1'b0;
                            sts_beats_q   <= beats_q + 9'd1;
                        end
                    end
                    StStatus: begin
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                endcase
            end
        end
    end

    assign rd_push = r_hs;
    assign rd_pop  = rd_ready_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rd_push) fifo_mem[wr_ptr_q] <= jtag_axi_miso_i.rdata;
    end

    always_ff @(posedge clk or negedge aresn) begin
        if (!aresn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (rd_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({rd_push, rd_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        axi_mosi         = '0;
        axi_mosi.awid    = AXI_ID_WIDTH'(AXI_MASTER_ID);
        axi_mosi.awaddr  = addr_q;
        axi_mosi.awlen   = len_q;
        axi_mosi.awsize  = size_q;
        axi_mosi.awburst = 2'b01;
        axi_mosi.awvalid = aw_valid_q;
        axi_mosi.wdata   = wr_data_i;
        axi_mosi.wstrb   = wr_strb_i;
        axi_mosi.wlast   = w_last;
        axi_mosi.wvalid  = (state_q == StW) && wr_valid_i;
        axi_mosi.bready  = (state_q == StB);
        axi_mosi.arid    = AXI_ID_WIDTH'(AXI_MASTER_ID);
        axi_mosi.araddr  = addr_q;
        axi_mosi.arlen   = len_q;
        axi_mosi.arsize  = size_q;
        axi_mosi.arburst = 2'b01;
        axi_mosi.arvalid = ar_valid_q;
        axi_mosi.rready  = r_ready;
    end

    assign jtag_axi_mosi_o = axi_mosi;
    assign unused_ids      = ^{jtag_axi_miso_i.bid, jtag_axi_miso_i.rid};

    assign req_ready_o   = req_ready_q;
    assign wr_ready_o    = (state_q == StW) && jtag_axi_miso_i.wready;
    assign rd_data_o     = fifo_mem[rd_ptr_q];
    assign rd_valid_o    = (count_q != '0);
    assign sts_valid_o   = sts_valid_q;
    assign sts_resp_o    = sts_resp_q;
    assign sts_timeout_o = sts_timeout_q;
    assign sts_illegal_o = sts_illegal_q;
    assign sts_beats_o   = sts_beats_q;
    assign busy_o        = (state_q != StIdle);
endmodule
